mem_fill_arbiter: RTL
=====================

// Module: mem_fill_arbiter
// PURPOSE
//  Shares the single pipelined main-memory port between I-cache and D-cache miss refills.
//  Grants one requester at a time, latches its block base, issues BLOCK_WORDS sequential reads.
//  Steers returned words into the granted cache.
//  Sits between the caches and main memory; the core stalls while its cache reports a miss.
// PARAMETERS
//  ADDR_W       16  byte address width
//  DATA_W       16  memory word width (2 bytes)
//  BLOCK_WORDS  8   words per cache block (power of 2, >=2)
//  CNT_W        3   log2(BLOCK_WORDS)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  i_miss         in   1       I-cache miss; held high until its block is filled
//  i_miss_addr    in   ADDR_W  I-cache miss byte address
//  d_miss         in   1       D-cache miss; held high until its block is filled
//  d_miss_addr    in   ADDR_W  D-cache miss byte address
//  mem_en         out  1       read request to memory, one per cycle
//  mem_addr       out  ADDR_W  read byte address
//  mem_valid      in   1       returned word valid (fixed memory latency, in order)
//  mem_rdata      in   DATA_W  returned word
//  grant_d        out  1       1 = current fill targets D-cache, 0 = I-cache
//  busy           out  1       fill in progress (state != IDLE)
//  fill_we        out  1       write fill_data into granted cache
//  fill_addr      out  ADDR_W  byte address of word being written
//  fill_data      out  DATA_W  = mem_rdata
//  fill_done      out  1       1-cycle pulse with last fill_we; cache writes tag/valid
// BEHAVIOUR
//  - Async reset (rst_n=0): state IDLE; issue_cnt=rx_cnt=0; base=0.
//    All outputs 0: mem_en, mem_addr, grant_d, busy, fill_we, fill_addr, fill_done.
//  - States: IDLE, ISSUE, DRAIN.
//  - IDLE: d_miss has priority over i_miss.
//    On any miss: latch base = miss_addr & ~(2*BLOCK_WORDS-1).
//    Set grant_d (1 if d_miss), clear counters, go to ISSUE.
//  - ISSUE: mem_en=1, mem_addr=base+2*issue_cnt; issue_cnt++.
//    After issue_cnt==BLOCK_WORDS-1 is issued, go to DRAIN.
//  - Any state != IDLE: on mem_valid, fill_we=1, fill_addr=base+2*rx_cnt, rx_cnt++.
//    Returns may arrive while still in ISSUE.
//  - When the word with rx_cnt==BLOCK_WORDS-1 is written: fill_done=1 same cycle, next state IDLE.
//    This can happen in ISSUE or DRAIN.
//  - Counters are CNT_W bits; base+offset never carries out of the block.
//  - Latency: miss seen in IDLE at cycle G; reads issued G+1..G+BLOCK_WORDS.
//    fill_done is on the last return (G+BLOCK_WORDS+LAT for memory latency LAT).
//  - No preemption: a d_miss arriving during an I fill waits for IDLE.
//  - Requester dropping its miss mid-fill: the fill still completes.
//  - Back-to-back fills: the cycle after fill_done is IDLE. The cache's miss is combinational,
//    so the just-filled requester is already low. The waiting requester is granted that cycle.
//  - mem_valid in IDLE (stale return after reset): ignored, fill_we=0.
//  - Reset mid-fill: immediate IDLE; the partial block is never signalled done.
//  - grant_d and base are stable from grant until fill_done.
// TESTING
//  - Lone i_miss, addr 0x1236, mem lat 4:
//    -> mem_addr 0x1230..0x123E on cycles G+1..G+8, grant_d=0.
//    -> 8 fill_we; fill_done at G+12.
//  - i_miss and d_miss rise together (0x0040 / 0x8006):
//    -> D served first (base 0x8000), then I (base 0x0040).
//    -> I is granted in the IDLE cycle after D's fill_done.
//  - d_miss rises during an I fill -> I fill completes untouched; D is granted afterwards.
//  - rst_n low at the 3rd return of a D fill:
//    -> outputs 0 immediately; later mem_valid pulses give fill_we=0.
//    -> no fill_done; a new miss restarts from word 0.
//  - Miss at 0xFFF4 -> addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
//  - i_miss drops mid-fill -> all 8 words still issued; fill_done still pulses.

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D-cache block refills onto one pipelined memory read port (D wins ties, no preemption).
// Grant seen in IDLE at G issues reads G+1..G+BLOCK_WORDS; fill_done rides on the last in-order return.
module mem_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int CNT_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_d,
    output logic              busy,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              grant_d_q, grant_d_d;

    // Base is block aligned, so OR-ing in the word offset can never carry out of the block.
    function automatic logic [ADDR_W-1:0] word_off(input logic [CNT_W-1:0] cnt);
        return ADDR_W'({cnt, 1'b0});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            base_q      <= '0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            base_q      <= base_d;
            grant_d_q   <= grant_d_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        base_d      = base_q;
        grant_d_d   = grant_d_q;
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_we     = 1'b0;
        fill_addr   = '0;
        fill_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_miss || i_miss) begin
                    grant_d_d   = d_miss;
                    base_d      = (d_miss ? d_miss_addr : i_miss_addr) & ~BLK_MASK;
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mem_en      = 1'b1;
                mem_addr    = base_q | word_off(issue_cnt_q);
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
            end
            default: state_d = IDLE;
        endcase

        // Returns may overlap issue; the final word ends the fill from either state.
        if (state_q != IDLE && mem_valid) begin
            fill_we   = 1'b1;
            fill_addr = base_q | word_off(rx_cnt_q);
            rx_cnt_d  = rx_cnt_q + 1'b1;
            if (rx_cnt_q == LAST) begin
                fill_done = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign grant_d   = grant_d_q;
    assign fill_data = mem_rdata;

endmodule
